// File: rtl/block_sf_48_dematrix_pkg.sv
// block_sf_48_dematrix_pkg: shared defaults, pairing-FSM encodings and saturation limits
package block_sf_48_dematrix_pkg;

    localparam int WIDTH_DEF     = 18;
    localparam int GAIN_W_DEF    = 4;
    localparam int GAIN_FRAC_DEF = 3;

    localparam int SAT_HI_DEF = (2 ** (WIDTH_DEF - 1)) - 1;
    localparam int SAT_LO_DEF = -(2 ** (WIDTH_DEF - 1));

    typedef enum logic [1:0] {
        WAIT_BOTH = 2'd0,
        HAVE_S    = 2'd1,
        HAVE_D    = 2'd2
    } pair_state_t;

endpackage

// File: rtl/sf_scale_sat.sv
// sf_scale_sat: per-channel gain scaling (floor) and saturation back to the sample width
module sf_scale_sat
    import block_sf_48_dematrix_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF,
    localparam int PW       = WIDTH + GAIN_W + 1,
    localparam int SW       = PW + 1
) (
    input  logic [WIDTH-1:0]  x_i,
    input  logic [GAIN_W-1:0] g_i,
    output logic [PW-1:0]     scaled_o,
    input  logic [SW-1:0]     wide_i,
    output logic [WIDTH-1:0]  sat_o
);

    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH - 1){1'b0}}};

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    logic [SW-WIDTH:0]    top_bits;

    // gain is unsigned, so it enters the signed product with a zero guard bit
    assign x_ext    = PW'($signed(x_i));
    assign g_ext    = PW'({1'b0, g_i});
    assign prod     = x_ext * g_ext;
    assign scaled_o = prod >>> GAIN_FRAC;

    // value fits when every bit above the target sign bit repeats the sign
    assign top_bits = wide_i[SW-1:WIDTH-1];
    assign sat_o    = (top_bits == {(SW - WIDTH + 1){wide_i[SW-1]}}) ? wide_i[WIDTH-1:0]
                    : (wide_i[SW-1] ? SAT_LO : SAT_HI);

endmodule

// File: rtl/block_sf_48_dematrix.sv
// block_sf_48_dematrix: pairs L+R / L-R samples and rebuilds saturated LEFT/RIGHT in a 3-stage pipe
module block_sf_48_dematrix
    import block_sf_48_dematrix_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  LpR_in,
    input  logic [WIDTH-1:0]  LmR_in,
    input  logic              ready_in_LpR,
    input  logic              ready_in_LmR,
    input  logic [GAIN_W-1:0] Gs,
    input  logic [GAIN_W-1:0] Gd,
    output logic [WIDTH-1:0]  LEFT,
    output logic [WIDTH-1:0]  RIGHT,
    output logic              ready_out,
    output logic              overrun
);

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam int SW = PW + 1;

    pair_state_t state_q, state_d;
    logic [WIDTH-1:0]  held_s_q, held_s_d, held_d_q, held_d_d;
    logic              launch, ovr_set;
    logic              v0_q, v1_q, v2_q;
    logic [WIDTH-1:0]  x_s_q, x_d_q;
    logic [GAIN_W-1:0] g_s_q, g_d_q;
    logic [PW-1:0]     scaled_s, scaled_d, s_s_q, s_d_q;
    logic signed [SW-1:0] sum_w, dif_w;
    logic [SW-1:0]     l_q, r_q;
    logic [WIDTH-1:0]  left_sat, right_sat;
    logic [WIDTH-1:0]  left_q, right_q;
    logic              ready_q, overrun_q;

    // pairing decisions; held samples always track the newest strobe so launch uses them directly
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        ovr_set  = 1'b0;
        held_s_d = ready_in_LpR ? LpR_in : held_s_q;
        held_d_d = ready_in_LmR ? LmR_in : held_d_q;
        case (state_q)
            WAIT_BOTH: begin
                launch  = ready_in_LpR && ready_in_LmR;
                state_d = launch ? WAIT_BOTH
                        : ready_in_LpR ? HAVE_S
                        : ready_in_LmR ? HAVE_D : WAIT_BOTH;
            end
            HAVE_S: begin
                launch  = ready_in_LmR;
                ovr_set = ready_in_LpR;
                state_d = ready_in_LmR ? WAIT_BOTH : HAVE_S;
            end
            HAVE_D: begin
                launch  = ready_in_LpR;
                ovr_set = ready_in_LmR;
                state_d = ready_in_LpR ? WAIT_BOTH : HAVE_D;
            end
            default: state_d = WAIT_BOTH;
        endcase
    end

    // pairing state, held samples and the sticky overrun flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_BOTH;
            held_s_q  <= '0;
            held_d_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_s_q  <= held_s_d;
            held_d_q  <= held_d_d;
            overrun_q <= overrun_q | ovr_set;
        end
    end

    // launch register: data pair and both gains captured together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v0_q  <= 1'b0;
            x_s_q <= '0;
            x_d_q <= '0;
            g_s_q <= '0;
            g_d_q <= '0;
        end else begin
            v0_q <= launch;
            if (launch) begin
                x_s_q <= held_s_d;
                x_d_q <= held_d_d;
                g_s_q <= Gs;
                g_d_q <= Gd;
            end
        end
    end

    sf_scale_sat #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_sum (
        .x_i      (x_s_q),
        .g_i      (g_s_q),
        .scaled_o (scaled_s),
        .wide_i   (l_q),
        .sat_o    (left_sat)
    );

    sf_scale_sat #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_dif (
        .x_i      (x_d_q),
        .g_i      (g_d_q),
        .scaled_o (scaled_d),
        .wide_i   (r_q),
        .sat_o    (right_sat)
    );

    // stage 1: scaled sum and difference channels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            s_s_q <= '0;
            s_d_q <= '0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                s_s_q <= scaled_s;
                s_d_q <= scaled_d;
            end
        end
    end

    assign sum_w = SW'($signed(s_s_q)) + SW'($signed(s_d_q));
    assign dif_w = SW'($signed(s_s_q)) - SW'($signed(s_d_q));

    // stage 2: matrix back to left/right with one guard bit, halved with floor
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v2_q <= 1'b0;
            l_q  <= '0;
            r_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                l_q <= sum_w >>> 1;
                r_q <= dif_w >>> 1;
            end
        end
    end

    // stage 3: saturated outputs, held between results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            ready_q <= v2_q;
            if (v2_q) begin
                left_q  <= left_sat;
                right_q <= right_sat;
            end
        end
    end

    assign LEFT      = left_q;
    assign RIGHT     = right_q;
    assign ready_out = ready_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_block_sf_48_dematrix.sv
// tb_block_sf_48_dematrix: random and directed stimulus checked every cycle against a pairing/arithmetic model
module tb_block_sf_48_dematrix;

    localparam int W = 18;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic signed [W-1:0] LpR_in = '0;
    logic signed [W-1:0] LmR_in = '0;
    logic ready_in_LpR = 1'b0;
    logic ready_in_LmR = 1'b0;
    logic [3:0] Gs = 4'd8;
    logic [3:0] Gd = 4'd8;
    logic signed [W-1:0] LEFT;
    logic signed [W-1:0] RIGHT;
    logic ready_out;
    logic overrun;

    block_sf_48_dematrix dut (
        .clock        (clock),
        .reset        (reset),
        .LpR_in       (LpR_in),
        .LmR_in       (LmR_in),
        .ready_in_LpR (ready_in_LpR),
        .ready_in_LmR (ready_in_LmR),
        .Gs           (Gs),
        .Gd           (Gd),
        .LEFT         (LEFT),
        .RIGHT        (RIGHT),
        .ready_out    (ready_out),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     due;
        longint l;
        longint r;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    longint hold_l = 0, hold_r = 0;
    bit     m_ovr = 0;
    bit     hs = 0, hd = 0;
    longint vs = 0, vd = 0;
    bit     er;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint fdiv(longint a, longint b);
        longint m;
        m = ((a % b) + b) % b;
        return (a - m) / b;
    endfunction

    function automatic longint clamp(longint a);
        if (a > 131071) return 131071;
        if (a < -131072) return -131072;
        return a;
    endfunction

    task automatic chk(string nm, longint act, longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, expv, cyc);
        end
    endtask

    task automatic launch(longint lp, longint lm, int gs, int gd);
        longint ss, sd;
        exp_t e;
        ss = fdiv(lp * gs, 8);
        sd = fdiv(lm * gd, 8);
        e.due = cyc + 4;
        e.l = clamp(fdiv(ss + sd, 2));
        e.r = clamp(fdiv(ss - sd, 2));
        q.push_back(e);
    endtask

    // one cycle of stimulus; the model is advanced for the upcoming rising edge
    task automatic step(bit s, bit d, longint lp, longint lm, int gs, int gd, bit rst_n);
        @(negedge clock);
        #1;
        reset = rst_n;
        ready_in_LpR = s;
        ready_in_LmR = d;
        LpR_in = W'(lp);
        LmR_in = W'(lm);
        Gs = 4'(gs);
        Gd = 4'(gd);
        if (!rst_n) begin
            q.delete();
            hold_l = 0;
            hold_r = 0;
            m_ovr = 0;
            hs = 0;
            hd = 0;
        end else if (s && d) begin
            if (hs || hd) m_ovr = 1;
            launch(lp, lm, gs, gd);
            hs = 0;
            hd = 0;
        end else if (s) begin
            if (hs) begin
                m_ovr = 1;
                vs = lp;
            end else if (hd) begin
                launch(lp, vd, gs, gd);
                hd = 0;
            end else begin
                vs = lp;
                hs = 1;
            end
        end else if (d) begin
            if (hd) begin
                m_ovr = 1;
                vd = lm;
            end else if (hs) begin
                launch(vs, lm, gs, gd);
                hs = 0;
            end else begin
                vd = lm;
                hd = 1;
            end
        end
    endtask

    task automatic idle(int n, int gs, int gd);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, gs, gd, 1);
    endtask

    function automatic longint rsamp();
        logic signed [W-1:0] t;
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return -131072;
        if (k == 1) return 131071;
        t = W'($urandom);
        return longint'(t);
    endfunction

    // every cycle: ready_out timing, held LEFT/RIGHT and sticky overrun against the model
    always @(negedge clock) begin
        er = (q.size() > 0) && (q[0].due == cyc);
        if (er) begin
            hold_l = q[0].l;
            hold_r = q[0].r;
            void'(q.pop_front());
        end
        chk("ready_out", longint'(ready_out), longint'(er));
        chk("LEFT", longint'(LEFT), hold_l);
        chk("RIGHT", longint'(RIGHT), hold_r);
        chk("overrun", longint'(overrun), longint'(m_ovr));
    end

    initial begin
        step(0, 0, 0, 0, 8, 8, 0);
        step(0, 0, 0, 0, 8, 8, 0);
        chk("reset_LEFT", longint'(LEFT), 0);
        chk("reset_ready", longint'(ready_out), 0);
        step(1, 1, 47, -17, 8, 8, 1);
        idle(4, 8, 8);
        chk("simul_LEFT", longint'(LEFT), 15);
        chk("simul_RIGHT", longint'(RIGHT), 32);
        chk("simul_ovr", longint'(overrun), 0);
        step(0, 1, 0, -17, 8, 8, 1);
        step(0, 0, 0, 0, 8, 8, 1);
        step(1, 0, 47, 0, 8, 8, 1);
        idle(2, 8, 8);
        chk("stag_early_ready", longint'(ready_out), 0);
        idle(2, 8, 8);
        chk("stag_LEFT", longint'(LEFT), 15);
        chk("stag_RIGHT", longint'(RIGHT), 32);
        step(1, 1, 131071, 131071, 15, 15, 1);
        idle(4, 3, 3);
        chk("sat_LEFT", longint'(LEFT), 131071);
        chk("sat_RIGHT", longint'(RIGHT), 0);
        step(1, 1, -3, 0, 8, 8, 1);
        idle(4, 8, 8);
        chk("floor_LEFT", longint'(LEFT), -2);
        chk("floor_RIGHT", longint'(RIGHT), -2);
        step(1, 0, 10, 0, 8, 8, 1);
        step(1, 0, 20, 0, 8, 8, 1);
        step(0, 1, 0, 4, 8, 8, 1);
        idle(4, 8, 8);
        chk("ovr_LEFT", longint'(LEFT), 12);
        chk("ovr_RIGHT", longint'(RIGHT), 8);
        chk("ovr_flag", longint'(overrun), 1);
        step(1, 0, 100, 0, 8, 8, 1);
        step(0, 0, 0, 0, 8, 8, 0);
        step(0, 1, 0, 30, 8, 8, 1);
        idle(4, 8, 8);
        chk("rst_ready", longint'(ready_out), 0);
        chk("rst_LEFT", longint'(LEFT), 0);
        chk("rst_RIGHT", longint'(RIGHT), 0);
        chk("rst_ovr", longint'(overrun), 0);
        step(1, 0, 50, 0, 8, 8, 1);
        idle(4, 8, 8);
        chk("have_d_LEFT", longint'(LEFT), 40);
        chk("have_d_RIGHT", longint'(RIGHT), 10);
        step(1, 1, 1000, 2000, 8, 8, 1);
        step(0, 0, 0, 0, 8, 8, 1);
        step(0, 0, 0, 0, 8, 8, 0);
        idle(5, 8, 8);
        chk("flush_LEFT", longint'(LEFT), 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 4) < 2, $urandom_range(0, 4) < 2, rsamp(), rsamp(),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 299) != 0);
        end
        idle(6, 8, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_sf_48_dematrix.md
BLOCK_SF_48_DEMATRIX -- requirements
Module: block_sf_48_dematrix

Interface
REQ-001 SHALL provide parameter WIDTH, default 18, sample width in bits (signed).
REQ-002 SHALL provide parameter GAIN_W, default 4, gain width in bits (unsigned).
REQ-003 SHALL provide parameter GAIN_FRAC, default 3, gain fractional bits (Gs=8 is unity).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port LpR_in  input  WIDTH  signed L+R sample.
REQ-007 SHALL have port LmR_in  input  WIDTH  signed L-R sample.
REQ-008 SHALL have port ready_in_LpR  input  1  one-cycle strobe; LpR_in valid this cycle.
REQ-009 SHALL have port ready_in_LmR  input  1  one-cycle strobe; LmR_in valid this cycle.
REQ-010 SHALL have port Gs  input  GAIN_W  sum-channel gain.
REQ-011 SHALL have port Gd  input  GAIN_W  difference-channel gain.
REQ-012 SHALL have port LEFT  output  WIDTH  signed reconstructed left sample.
REQ-013 SHALL have port RIGHT  output  WIDTH  signed reconstructed right sample.
REQ-014 SHALL have port ready_out  output  1  one-cycle strobe; LEFT/RIGHT valid.
REQ-015 SHALL have port overrun  output  1  sticky flag; a held sample was overwritten.

Function
REQ-016 SHALL run a pairing FSM with states WAIT_BOTH, HAVE_S, HAVE_D; reset state WAIT_BOTH.
REQ-017 WAIT_BOTH: LpR strobe only -> capture, HAVE_S; LmR strobe only -> capture, HAVE_D; both -> capture both, launch, stay.
REQ-018 HAVE_S: LmR strobe -> capture, launch, WAIT_BOTH; LpR strobe alone -> overwrite held LpR, set overrun, stay.
REQ-019 HAVE_D: mirror of REQ-018 with streams swapped.
REQ-020 HAVE_S/HAVE_D with both strobes in same cycle: newest LpR and LmR used, launch, WAIT_BOTH, overrun set.
REQ-021 Gs and Gd SHALL be sampled in the launch cycle, together with the data pair.
REQ-022 Stage 1: sS = (LpR * Gs) >>> GAIN_FRAC, sD = (LmR * Gd) >>> GAIN_FRAC, gain zero-extended, full-precision product, arithmetic shift (floor, no rounding).
REQ-023 Stage 2: L = (sS + sD) >>> 1, R = (sS - sD) >>> 1, one guard bit added, floor.
REQ-024 Stage 3: LEFT/RIGHT SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and register with ready_out.
REQ-025 ready_out SHALL assert exactly 3 clocks after the edge sampling the completing strobe.
REQ-026 Pipeline SHALL accept one launch per cycle; ready_out may be high on consecutive cycles.
REQ-027 LEFT/RIGHT SHALL hold their last value while ready_out is low.
REQ-028 overrun SHALL stay high until reset once set.

Reset
REQ-029 reset low SHALL immediately force LEFT=0, RIGHT=0, ready_out=0, overrun=0, FSM=WAIT_BOTH, holding and pipeline registers and valids cleared.
REQ-030 Reset mid-operation SHALL discard held samples and in-flight pipeline data; no ready_out for them after release.
REQ-031 Strobes in the first edge after reset release SHALL be processed normally.

Structure
REQ-032 Shared package SHALL hold WIDTH/GAIN_W/GAIN_FRAC defaults, FSM state encodings, and saturation limits.
REQ-033 Scale-and-saturate arithmetic SHALL be one sub-module, sf_scale_sat, instanced for the two channels.

Verification
REQ-034 Gs=Gd=8, simultaneous LpR=47, LmR=-17 -> LEFT=15, RIGHT=32, ready_out 3 cycles later, overrun=0.
REQ-035 Gs=Gd=8, LmR=-17 then LpR=47 two cycles later -> LEFT=15, RIGHT=32, 3 cycles after LpR strobe.
REQ-036 Gs=Gd=15, LpR=LmR=131071 -> LEFT=131071 (saturated), RIGHT=0.
REQ-037 Gs=Gd=8, LpR=-3, LmR=0 -> LEFT=-2, RIGHT=-2 (floor).
REQ-038 Gs=Gd=8, LpR=10, LpR=20, then LmR=4 -> LEFT=12, RIGHT=8, overrun=1.
REQ-039 LpR strobe, reset pulsed low, then lone LmR strobe -> no ready_out, outputs 0, FSM HAVE_D.
